// File: rtl/mem_responder.sv
// mem_responder: memory-side bus responder for the core's 24-bit word address,
// 16-bit data synchronous bus. Each cycle's Address is decoded to the block
// RAM, a small bank of memory-mapped registers, or unmapped space. Read data
// always appears one cycle after the address, for every target.
//
// Ports:
//   clk          system clock, rising-edge registers
//   rst_n        asynchronous active-low reset
//   Address      core word address (valid every cycle)
//   WriteData    core write data
//   WriteEnable  core write strobe for the current cycle
//   ReadData     read data, valid the cycle after Address
//   RamAddr      RAM port A address (Address[14:0])
//   RamWe        RAM port A write enable (combinational, 0 in reset)
//   RamDin       RAM port A write data (WriteData)
//   RamDout      RAM port A read data (one-cycle latency)
//   LedOut       LED register contents
//   BusError     one-cycle pulse, aligned with ReadData, for an unmapped or
//                protected access
//
// Configuration macro: MEM_RESP_WPROT_EN -- when defined, RAM words
// 0x000000-0x0000FF are write-protected (write dropped, BusError raised,
// address captured).
//
// MMIO map (word addresses):
//   0x800000 LED (rw), 0x800001 TimerLo (r, write clears timer),
//   0x800002 TimerHi snapshot (r), 0x800003 Scratch (rw),
//   0x800004 ErrStatus ({addr[23:16], 7'b0, flag}, write 1 to bit0 clears),
//   0x800005 ErrAddrLo (r)

module mem_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] Address,
  input  logic [15:0] WriteData,
  input  logic        WriteEnable,
  output logic [15:0] ReadData,
  output logic [14:0] RamAddr,
  output logic        RamWe,
  output logic [15:0] RamDin,
  input  logic [15:0] RamDout,
  output logic [15:0] LedOut,
  output logic        BusError
);

  typedef enum logic [1:0] {
    SEL_UNMAP = 2'd0,
    SEL_RAM   = 2'd1,
    SEL_MMIO  = 2'd2
  } selT;

  selT         sel_r;
  logic [15:0] mmioRead_r;
  logic [15:0] led_r;
  logic [15:0] scratch_r;
  logic [31:0] timer_r;
  logic [15:0] timerSnap_r;
  logic        errFlag_r;
  logic [7:0]  errAddrHi_r;
  logic [15:0] errAddrLo_r;
  logic        busErr_r;

  logic        ramHit_s;
  logic        mmioHit_s;
  logic        protErr_s;
  logic        errHit_s;
  logic [15:0] mmioRdVal_s;
  logic        wrLed_s;
  logic        wrTimerLo_s;
  logic        rdTimerLo_s;
  logic        wrScratch_s;
  logic        wrErrStat_s;

  // Address decode
  assign ramHit_s  = (Address[23:15] == 9'd0);
  assign mmioHit_s = (Address[23:3] == 21'h100000) && (Address[2:0] <= 3'd5);

`ifdef MEM_RESP_WPROT_EN
  // Boot region writes are refused and reported as errors.
  assign protErr_s = WriteEnable & (Address[23:8] == 16'd0);
`else
  assign protErr_s = 1'b0;
`endif

  assign errHit_s = (~ramHit_s & ~mmioHit_s) | protErr_s;

  assign wrLed_s     = WriteEnable & mmioHit_s & (Address[2:0] == 3'd0);
  assign wrTimerLo_s = WriteEnable & mmioHit_s & (Address[2:0] == 3'd1);
  assign rdTimerLo_s = ~WriteEnable & mmioHit_s & (Address[2:0] == 3'd1);
  assign wrScratch_s = WriteEnable & mmioHit_s & (Address[2:0] == 3'd3);
  assign wrErrStat_s = WriteEnable & mmioHit_s & (Address[2:0] == 3'd4);

  // RAM port A: address and data pass straight through, write gated by decode
  assign RamAddr = Address[14:0];
  assign RamDin  = WriteData;
  assign RamWe   = rst_n & WriteEnable & ramHit_s & ~protErr_s;

  assign LedOut   = led_r;
  assign BusError = busErr_r;

  // MMIO read value from current (pre-write) register contents
  always_comb begin
    mmioRdVal_s = 16'h0000;
    case (Address[2:0])
      3'd0:    mmioRdVal_s = led_r;
      3'd1:    mmioRdVal_s = timer_r[15:0];
      3'd2:    mmioRdVal_s = timerSnap_r;
      3'd3:    mmioRdVal_s = scratch_r;
      3'd4:    mmioRdVal_s = {errAddrHi_r, 7'd0, errFlag_r};
      3'd5:    mmioRdVal_s = errAddrLo_r;
      default: mmioRdVal_s = 16'h0000;
    endcase
  end

  // Read-data select, registered to line up with the RAM's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r      <= SEL_UNMAP;
      mmioRead_r <= 16'h0000;
      busErr_r   <= 1'b0;
    end else begin
      busErr_r <= errHit_s;
      if (mmioHit_s) begin
        mmioRead_r <= mmioRdVal_s;
      end else begin
        mmioRead_r <= mmioRead_r;
      end
      if (ramHit_s) begin
        sel_r <= SEL_RAM;
      end else if (mmioHit_s) begin
        sel_r <= SEL_MMIO;
      end else begin
        sel_r <= SEL_UNMAP;
      end
    end
  end

  // Read-data output mux
  always_comb begin
    ReadData = 16'h0000;
    case (sel_r)
      SEL_RAM:   ReadData = RamDout;
      SEL_MMIO:  ReadData = mmioRead_r;
      SEL_UNMAP: ReadData = 16'h0000;
      default:   ReadData = 16'h0000;
    endcase
  end

  // LED and scratch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r     <= 16'h0000;
      scratch_r <= 16'h0000;
    end else begin
      if (wrLed_s)     led_r     <= WriteData;
      if (wrScratch_s) scratch_r <= WriteData;
    end
  end

  // Free-running timer; a TimerLo read snapshots the upper half so a
  // following TimerHi read is coherent with the low half already returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r     <= 32'd0;
      timerSnap_r <= 16'h0000;
    end else begin
      if (wrTimerLo_s) begin
        timer_r <= 32'd0;
      end else begin
        timer_r <= timer_r + 32'd1;
      end
      if (rdTimerLo_s) begin
        timerSnap_r <= timer_r[31:16];
      end else begin
        timerSnap_r <= timerSnap_r;
      end
    end
  end

  // Error capture: the first error after the flag is cleared wins; a new
  // error outranks a simultaneous write-1-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errFlag_r   <= 1'b0;
      errAddrHi_r <= 8'h00;
      errAddrLo_r <= 16'h0000;
    end else if (errHit_s) begin
      if (!errFlag_r) begin
        errFlag_r   <= 1'b1;
        errAddrHi_r <= Address[23:16];
        errAddrLo_r <= Address[15:0];
      end
    end else if (wrErrStat_s && WriteData[0]) begin
      errFlag_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [23:0] Address;
  logic [15:0] WriteData;
  logic        WriteEnable;
  logic [15:0] ReadData;
  logic [14:0] RamAddr;
  logic        RamWe;
  logic [15:0] RamDin;
  logic [15:0] RamDout = 16'h0000;
  logic [15:0] LedOut;
  logic        BusError;

  int total = 0;
  int bad   = 0;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .WriteData(WriteData),
    .WriteEnable(WriteEnable), .ReadData(ReadData), .RamAddr(RamAddr),
    .RamWe(RamWe), .RamDin(RamDin), .RamDout(RamDout), .LedOut(LedOut),
    .BusError(BusError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model: read-first, one-cycle latency, unwritten words read 0
  logic [15:0] ramMem [int];
  always @(posedge clk) begin
    RamDout <= ramMem.exists(int'(RamAddr)) ? ramMem[int'(RamAddr)] : 16'h0000;
    if (RamWe) ramMem[int'(RamAddr)] = RamDin;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle, no checks; returns at the following falling edge
  task automatic access(input logic [23:0] a, input logic we, input logic [15:0] wd);
    Address = a; WriteEnable = we; WriteData = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [15:0] wd;
    logic        expRamWe;
    logic [15:0] expRd;
    logic [15:0] expLed;
    logic        expErr;
  } vecT;

  localparam int NV = 25;
  vecT vecs [NV];

  logic wprot;

  initial begin
`ifdef MEM_RESP_WPROT_EN
    wprot = 1'b1;
`else
    wprot = 1'b0;
`endif
    //               addr        we    wd       ramWe rd        led       err
    vecs[0]  = '{24'h800000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{24'h800003, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{24'h800004, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{24'h800000, 1'b1, 16'h00A5, 1'b0, 16'h0000, 16'h00A5, 1'b0};
    vecs[4]  = '{24'h800000, 1'b0, 16'h0000, 1'b0, 16'h00A5, 16'h00A5, 1'b0};
    vecs[5]  = '{24'h800003, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h00A5, 1'b0};
    vecs[6]  = '{24'h800003, 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h00A5, 1'b0};
    vecs[7]  = '{24'h800002, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h00A5, 1'b0};
    vecs[8]  = '{24'h800002, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h00A5, 1'b0};
    vecs[9]  = '{24'h123456, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 16'h00A5, 1'b1};
    vecs[10] = '{24'h800004, 1'b0, 16'h0000, 1'b0, 16'h1201, 16'h00A5, 1'b0};
    vecs[11] = '{24'h800005, 1'b0, 16'h0000, 1'b0, 16'h3456, 16'h00A5, 1'b0};
    vecs[12] = '{24'h400000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h00A5, 1'b1};
    vecs[13] = '{24'h800006, 1'b1, 16'h7777, 1'b0, 16'h0000, 16'h00A5, 1'b1};
    vecs[14] = '{24'h800005, 1'b0, 16'h0000, 1'b0, 16'h3456, 16'h00A5, 1'b0};
    vecs[15] = '{24'h800004, 1'b0, 16'h0000, 1'b0, 16'h1201, 16'h00A5, 1'b0};
    vecs[16] = '{24'h800004, 1'b1, 16'h0001, 1'b0, 16'h1201, 16'h00A5, 1'b0};
    vecs[17] = '{24'h800004, 1'b0, 16'h0000, 1'b0, 16'h1200, 16'h00A5, 1'b0};
    vecs[18] = '{24'h000200, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 16'h00A5, 1'b0};
    vecs[19] = '{24'h000200, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 16'h00A5, 1'b0};
    vecs[20] = '{24'h000010, 1'b1, 16'h5555, ~wprot, 16'h0000, 16'h00A5, wprot};
    vecs[21] = '{24'h800005, 1'b0, 16'h0000, 1'b0, wprot ? 16'h0010 : 16'h3456, 16'h00A5, 1'b0};
    vecs[22] = '{24'h000010, 1'b0, 16'h0000, 1'b0, wprot ? 16'h0000 : 16'h5555, 16'h00A5, 1'b0};
    vecs[23] = '{24'h800000, 1'b1, 16'h00FF, 1'b0, 16'h00A5, 16'h00FF, 1'b0};
    vecs[24] = '{24'h800000, 1'b0, 16'h0000, 1'b0, 16'h00FF, 16'h00FF, 1'b0};

    rst_n = 1'b0; Address = 24'h0; WriteData = 16'h0; WriteEnable = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ReadData", {16'h0, ReadData}, 32'h0);
    check("reset LedOut",   {16'h0, LedOut},   32'h0);
    check("reset BusError", {31'h0, BusError}, 32'h0);
    rst_n = 1'b1;

    // Table: drive at the falling edge, results checked one cycle later
    for (int i = 0; i < NV; i++) begin
      Address = vecs[i].addr; WriteEnable = vecs[i].we; WriteData = vecs[i].wd;
      #1;
      check($sformatf("v%0d RamWe", i),   {31'h0, RamWe}, {31'h0, vecs[i].expRamWe});
      check($sformatf("v%0d RamAddr", i), {17'h0, RamAddr}, {17'h0, vecs[i].addr[14:0]});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d ReadData", i), {16'h0, ReadData}, {16'h0, vecs[i].expRd});
      check($sformatf("v%0d LedOut", i),   {16'h0, LedOut},   {16'h0, vecs[i].expLed});
      check($sformatf("v%0d BusError", i), {31'h0, BusError}, {31'h0, vecs[i].expErr});
    end

    // Timer: clear, run to 0x0000FFFF, then check low read, snapshot and carry
    access(24'h800001, 1'b1, 16'h0000);         // cycle N0: counter 0 after edge
    repeat (16'hFFFF) access(24'h800003, 1'b0, 16'h0000);
    access(24'h800001, 1'b0, 16'h0000);         // counter = 0x0000FFFF
    check("timerLo at 0xFFFF", {16'h0, ReadData}, 32'h0000FFFF);
    access(24'h800002, 1'b0, 16'h0000);
    check("timerHi snapshot 0", {16'h0, ReadData}, 32'h0);
    access(24'h800001, 1'b0, 16'h0000);         // counter = 0x00010001
    check("timerLo after carry", {16'h0, ReadData}, 32'h0001);
    access(24'h800002, 1'b0, 16'h0000);
    check("timerHi after carry", {16'h0, ReadData}, 32'h0001);
    check("timer no error", {31'h0, BusError}, 32'h0);

    // Reset asserted in the middle of a RAM write
    Address = 24'h000300; WriteEnable = 1'b1; WriteData = 16'h1111;
    #1;
    check("pre-reset RamWe", {31'h0, RamWe}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid-reset RamWe",    {31'h0, RamWe},    32'h0);
    check("mid-reset LedOut",   {16'h0, LedOut},   32'h0);
    check("mid-reset ReadData", {16'h0, ReadData}, 32'h0);
    check("mid-reset BusError", {31'h0, BusError}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(24'h800002, 1'b0, 16'h0000);
    check("post-reset snapshot", {16'h0, ReadData}, 32'h0);
    access(24'h800004, 1'b0, 16'h0000);
    check("post-reset ErrStatus", {16'h0, ReadData}, 32'h0);
    access(24'h000300, 1'b0, 16'h0000);
    check("reset dropped RAM write", {16'h0, ReadData}, 32'h0);
    access(24'h800000, 1'b0, 16'h0000);
    check("post-reset LED read", {16'h0, ReadData}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
